// File: rtl/mpadd_pkg.sv
// rtl/mpadd_pkg.sv - shared types and default sizes for the multi-word adder sequencer
package mpadd_pkg;

  localparam int unsigned DEF_WORD_W    = 32;
  localparam int unsigned DEF_MAX_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/mpadd_word_adder.sv
// rtl/mpadd_word_adder.sv - combinational carry-in adder, 4-bit look-ahead groups rippled together
module mpadd_word_adder #(
  parameter int unsigned WORD_W = 32
) (
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              cout_o
);

  localparam int unsigned NGRP  = (WORD_W + 3) / 4;
  localparam int unsigned PAD_W = NGRP * 4;

  logic [PAD_W-1:0] a_p;
  logic [PAD_W-1:0] b_p;
  logic [PAD_W-1:0] g;
  logic [PAD_W-1:0] p;
  logic [PAD_W-1:0] s_p;
  logic [NGRP:0]    gc;

  assign a_p   = PAD_W'(a_i);
  assign b_p   = PAD_W'(b_i);
  assign g     = a_p & b_p;
  assign p     = a_p ^ b_p;
  assign gc[0] = cin_i;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    logic [3:0] gg;
    logic [3:0] pp;
    logic       c0, c1, c2, c3, c4;

    assign gg = g[4*k +: 4];
    assign pp = p[4*k +: 4];
    assign c0 = gc[k];
    assign c1 = gg[0] | (pp[0] & c0);
    assign c2 = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
    assign c3 = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
              | (pp[2] & pp[1] & pp[0] & c0);
    assign c4 = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
              | (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & c0);

    assign s_p[4*k +: 4] = pp ^ {c3, c2, c1, c0};
    assign gc[k+1]       = c4;
  end

  assign sum_o = s_p[WORD_W-1:0];

  // With zero padding the carry into bit WORD_W surfaces as that pad sum bit.
  if (PAD_W == WORD_W) begin : g_cout_exact
    assign cout_o = gc[NGRP];
  end else begin : g_cout_pad
    assign cout_o = s_p[WORD_W];
  end

endmodule

// File: rtl/mpadd_sequencer.sv
// rtl/mpadd_sequencer.sv - streams LS-first operand words through one adder, chaining carry/borrow
module mpadd_sequencer
  import mpadd_pkg::*;
#(
  parameter  int unsigned WORD_W    = DEF_WORD_W,
  parameter  int unsigned MAX_WORDS = DEF_MAX_WORDS,
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_nwords,
  input  logic              cmd_sub,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [WORD_W-1:0] op_x,
  input  logic [WORD_W-1:0] op_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_sum,
  output logic              res_last,
  output logic              res_carry,
  output logic              res_ovf,
  output logic              done,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               carry_q, carry_d;
  logic               sub_q, sub_d;
  logic               rv_q, rv_d;
  logic [WORD_W-1:0]  sum_q, sum_d;
  logic               last_q, last_d;
  logic               rc_q, rc_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [WORD_W-1:0]  y_eff;
  logic [WORD_W-1:0]  add_sum;
  logic               add_cout;
  logic [CNT_W-1:0]   nwords_clamped;
  logic               cmd_fire, op_fire, res_fire;

  // Subtraction is X + ~Y + 1; the +1 comes from seeding the carry with cmd_sub.
  assign y_eff = sub_q ? ~op_y : op_y;

  mpadd_word_adder #(.WORD_W(WORD_W)) u_adder (
    .a_i    (op_x),
    .b_i    (y_eff),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign cmd_ready = (state_q == IDLE);
  assign op_ready  = (state_q == RUN) && (!rv_q || res_ready);
  assign busy      = (state_q != IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign op_fire   = op_valid && op_ready;
  assign res_fire  = rv_q && res_ready;

  assign nwords_clamped = (cmd_nwords > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : cmd_nwords;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    rv_d    = rv_q;
    sum_d   = sum_q;
    last_d  = last_q;
    rc_d    = rc_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (nwords_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            sub_d   = cmd_sub;
            carry_d = cmd_sub;
            count_d = nwords_clamped;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (res_fire) begin
          rv_d = 1'b0;
        end
        if (op_fire) begin
          rv_d    = 1'b1;
          sum_d   = add_sum;
          carry_d = add_cout;
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            last_d  = 1'b1;
            rc_d    = sub_q ? ~add_cout : add_cout;
            ovf_d   = (op_x[WORD_W-1] == y_eff[WORD_W-1]) &&
                      (add_sum[WORD_W-1] != op_x[WORD_W-1]);
            state_d = DRAIN;
          end else begin
            last_d = 1'b0;
            rc_d   = 1'b0;
            ovf_d  = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (res_fire) begin
          rv_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      rv_q    <= 1'b0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      rc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      rv_q    <= rv_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      rc_q    <= rc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign res_valid = rv_q;
  assign res_sum   = sum_q;
  assign res_last  = last_q;
  assign res_carry = rc_q;
  assign res_ovf   = ovf_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mpadd_sequencer.sv
// tb/tb_mpadd_sequencer.sv - randomized bench for mpadd_sequencer against a big-integer model
module tb_mpadd_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_nwords;
  logic             cmd_sub;
  logic             op_valid;
  logic             op_ready;
  logic [31:0]      op_x;
  logic [31:0]      op_y;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_sum;
  logic             res_last;
  logic             res_carry;
  logic             res_ovf;
  logic             done;
  logic             busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mpadd_sequencer #(.WORD_W(32), .MAX_WORDS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_nwords (cmd_nwords),
    .cmd_sub    (cmd_sub),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_x       (op_x),
    .op_y       (op_y),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_last   (res_last),
    .res_carry  (res_carry),
    .res_ovf    (res_ovf),
    .done       (done),
    .busy       (busy)
  );

  // Whole-operand arithmetic on n*32-bit unsigned values; carry is carry-out or borrow.
  function automatic void model(input int n, input bit sub, input logic [255:0] x,
                                input logic [255:0] y, output logic [255:0] r,
                                output bit carry, output bit ovf);
    logic [256:0] t;
    logic [255:0] mask;
    logic [255:0] xs, ys;
    int msb;
    mask = (n >= 8) ? {256{1'b1}} : ((256'(1) << (n * 32)) - 256'(1));
    msb  = n * 32 - 1;
    xs   = x & mask;
    ys   = y & mask;
    if (sub) begin
      t     = {1'b0, xs} - {1'b0, ys};
      carry = (xs < ys);
    end else begin
      t     = {1'b0, xs} + {1'b0, ys};
      carry = t[n * 32];
    end
    r = t[255:0] & mask;
    if (sub) ovf = (xs[msb] != ys[msb]) && (r[msb] != xs[msb]);
    else     ovf = (xs[msb] == ys[msb]) && (r[msb] != xs[msb]);
  endfunction

  // mode 0: full rate, 1: random gaps and random res_ready, 2: 5-cycle sink stall
  task automatic run_op(input int ncmd, input bit sub, input logic [255:0] x,
                        input logic [255:0] y, input int mode);
    int n, si, ri, cyc, stall_cnt;
    logic [255:0] r;
    bit exp_c, exp_v, prev_stall, acc_prev, ofire, rfire;
    logic [31:0] held, exp_w;
    n = (ncmd > 8) ? 8 : ncmd;
    model(n, sub, x, y, r, exp_c, exp_v);

    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_nwords = ncmd[CNT_W-1:0];
    cmd_sub    = sub;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready: got %b expected 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    if (n == 0) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_words: done=%b res_valid=%b busy=%b expected 1 0 0",
                 done, res_valid, busy);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL zero_done_pulse: got %b expected 0", done);
      end
      return;
    end

    si = 0; ri = 0; cyc = 0; stall_cnt = 0;
    prev_stall = 1'b0; acc_prev = 1'b0; held = '0;
    while (ri < n && cyc < 300) begin
      op_valid = (si < n) && (mode != 1 || $urandom_range(0, 3) != 0);
      if (si < n) begin
        op_x = x[si*32 +: 32];
        op_y = y[si*32 +: 32];
      end else begin
        op_x = $urandom;
        op_y = $urandom;
      end
      case (mode)
        1:       res_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (ri == 1 && stall_cnt < 5) begin
            res_ready = 1'b0;
            stall_cnt++;
          end else begin
            res_ready = 1'b1;
          end
        end
        default: res_ready = 1'b1;
      endcase
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL early_done: got %b expected 0 (word %0d)", done, ri);
      end
      if (acc_prev) begin
        checks++;
        if (res_valid !== 1'b1) begin
          errors++;
          $display("FAIL latency: res_valid=%b expected 1 one cycle after accept", res_valid);
        end
      end
      if (prev_stall) begin
        checks++;
        if (res_valid !== 1'b1 || res_sum !== held) begin
          errors++;
          $display("FAIL stall_hold: res_valid=%b res_sum=%h expected 1 %h",
                   res_valid, res_sum, held);
        end
      end
      if (res_valid === 1'b1 && res_ready === 1'b0) begin
        checks++;
        if (op_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_op_ready: got %b expected 0", op_ready);
        end
      end
      if (mode == 0 && si < n) begin
        checks++;
        if (op_ready !== 1'b1) begin
          errors++;
          $display("FAIL full_rate: op_ready=%b expected 1 at word %0d", op_ready, si);
        end
      end
      ofire = op_valid && (op_ready === 1'b1);
      rfire = (res_valid === 1'b1) && res_ready;
      if (rfire) begin
        exp_w = r[ri*32 +: 32];
        checks++;
        if (res_sum !== exp_w || res_last !== (ri == n - 1)) begin
          errors++;
          $display("FAIL res_word%0d: sum=%h last=%b expected %h %b",
                   ri, res_sum, res_last, exp_w, (ri == n - 1));
        end
        checks++;
        if (ri == n - 1) begin
          if (res_carry !== exp_c || res_ovf !== exp_v) begin
            errors++;
            $display("FAIL res_flags: carry=%b ovf=%b expected %b %b",
                     res_carry, res_ovf, exp_c, exp_v);
          end
        end else if (res_carry !== 1'b0 || res_ovf !== 1'b0) begin
          errors++;
          $display("FAIL mid_flags: carry=%b ovf=%b expected 0 0", res_carry, res_ovf);
        end
        ri++;
      end
      prev_stall = (res_valid === 1'b1) && !res_ready;
      held       = res_sum;
      acc_prev   = ofire;
      if (ofire) si++;
      @(posedge clk); #1;
      cyc++;
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    checks++;
    if (ri != n) begin
      errors++;
      $display("FAIL timeout: got %0d words expected %0d", ri, n);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != n + 1) begin
        errors++;
        $display("FAIL throughput: took %0d cycles expected %0d", cyc, n + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b res_valid=%b expected 1 0 0",
               done, busy, res_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_clear: done=%b cmd_ready=%b expected 0 1", done, cmd_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, op_ready, res_valid, res_last, res_carry, res_ovf, done, busy} !== 8'b1000_0000
        || res_sum !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%h expected 10000000/00000000",
               {cmd_ready, op_ready, res_valid, res_last, res_carry, res_ovf, done, busy}, res_sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    run_op(1, 1'b0, 256'hFFFFFFFF, 256'h1, 0);
    run_op(2, 1'b0, {192'h0, 32'h00000000, 32'hFFFFFFFF}, 256'h1, 0);
    run_op(3, 1'b1, 256'h0, 256'h1, 0);
    run_op(1, 1'b0, 256'h7FFFFFFF, 256'h1, 0);
    run_op(1, 1'b1, 256'h80000000, 256'h1, 0);
  endtask

  task automatic test_backpressure;
    logic [255:0] x, y;
    for (int i = 0; i < 8; i++) begin
      x[i*32 +: 32] = $urandom;
      y[i*32 +: 32] = $urandom;
    end
    run_op(4, 1'b0, x, y, 2);
    run_op(4, 1'b1, x, y, 2);
  endtask

  task automatic test_edges;
    logic [255:0] x, y;
    run_op(0, 1'b0, 256'h5, 256'h6, 0);
    for (int i = 0; i < 8; i++) begin
      x[i*32 +: 32] = $urandom;
      y[i*32 +: 32] = $urandom;
    end
    run_op(13, 1'b1, x, y, 0);
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_nwords = 4'd4; cmd_sub = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    op_valid = 1'b1; res_ready = 1'b1; op_x = 32'hFFFFFFFF; op_y = 32'h1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b res_valid=%b cmd_ready=%b done=%b expected 0 0 1 0",
               busy, res_valid, cmd_ready, done);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_done: got %b expected 0", done);
      end
    end
    run_op(1, 1'b0, 256'h5, 256'h6, 0);
    run_op(2, 1'b1, 256'h9, 256'h3, 0);
  endtask

  task automatic test_random;
    logic [255:0] x, y;
    int n;
    bit sub;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 3))
          0:       x[i*32 +: 32] = 32'hFFFFFFFF;
          1:       x[i*32 +: 32] = 32'h0;
          default: x[i*32 +: 32] = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0:       y[i*32 +: 32] = 32'hFFFFFFFF;
          1:       y[i*32 +: 32] = 32'h0;
          default: y[i*32 +: 32] = $urandom;
        endcase
      end
      n   = $urandom_range(0, 10);
      sub = 1'($urandom_range(0, 1));
      run_op(n, sub, x, y, int'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_nwords = '0; cmd_sub = 1'b0;
    op_valid = 1'b0; op_x = '0; op_y = '0; res_ready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_edges();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
